// File: rtl/core_lsu_if.sv
// core_lsu bus bundle: core request, dmem request/response and writeback.
// slave is the LSU view; master is the core/dmem/testbench view.
interface core_lsu_if #(
  parameter int data_width_p = 32,
  parameter int addr_width_p = 32,
  parameter int rd_width_p   = 5
);
  logic                      req_valid_i;
  logic                      req_ready_o;
  logic                      req_wen_i;
  logic [1:0]                req_size_i;
  logic                      req_signed_i;
  logic [addr_width_p-1:0]   req_addr_i;
  logic [data_width_p-1:0]   req_wdata_i;
  logic [rd_width_p-1:0]     req_rd_i;
  logic                      mem_valid_o;
  logic                      mem_yumi_i;
  logic                      mem_wen_o;
  logic [data_width_p/8-1:0] mem_be_o;
  logic [addr_width_p-1:0]   mem_addr_o;
  logic [data_width_p-1:0]   mem_wdata_o;
  logic                      mem_rvalid_i;
  logic [data_width_p-1:0]   mem_rdata_i;
  logic                      mem_ryumi_o;
  logic                      wb_valid_o;
  logic [rd_width_p-1:0]     wb_rd_o;
  logic [data_width_p-1:0]   wb_data_o;
  logic                      wb_yumi_i;
  logic                      busy_o;
  logic                      exception_o;

  modport slave (
    input  req_valid_i, req_wen_i, req_size_i, req_signed_i,
    input  req_addr_i, req_wdata_i, req_rd_i,
    output req_ready_o,
    output mem_valid_o, mem_wen_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_yumi_i, mem_rvalid_i, mem_rdata_i,
    output mem_ryumi_o,
    output wb_valid_o, wb_rd_o, wb_data_o,
    input  wb_yumi_i,
    output busy_o, exception_o
  );

  modport master (
    output req_valid_i, req_wen_i, req_size_i, req_signed_i,
    output req_addr_i, req_wdata_i, req_rd_i,
    input  req_ready_o,
    input  mem_valid_o, mem_wen_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_yumi_i, mem_rvalid_i, mem_rdata_i,
    input  mem_ryumi_o,
    input  wb_valid_o, wb_rd_o, wb_data_o,
    output wb_yumi_i,
    input  busy_o, exception_o
  );
endinterface

// File: rtl/core_lsu.sv
// Load/store unit: multi-outstanding, in-order, sized and sign-extended.
// CORE_LSU_STATS_EN adds stall_cycles_o, a saturating stall counter.
module core_lsu #(
  parameter int data_width_p  = 32,
  parameter int addr_width_p  = 32,
  parameter int outstanding_p = 2,
  parameter int rd_width_p    = 5
) (
  input logic clk,
  input logic reset,
  core_lsu_if.slave bus
`ifdef CORE_LSU_STATS_EN
  ,
  output logic [31:0] stall_cycles_o
`endif
);

  localparam int byte_w = data_width_p / 8;
  localparam int off_w  = $clog2(byte_w);
  localparam int ptr_w  = (outstanding_p > 1) ? $clog2(outstanding_p) : 1;
  localparam int cnt_w  = $clog2(outstanding_p + 1);

  typedef struct packed {
    logic                  wen;
    logic [1:0]            size;
    logic                  sgn;
    logic [off_w-1:0]      off;
    logic [rd_width_p-1:0] rd;
  } trk_t;

  trk_t fifo_q [outstanding_p];

  logic [ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [cnt_w-1:0] count_q, count_d;

  logic                    iss_valid_q, iss_valid_d;
  logic                    iss_wen_q, iss_wen_d;
  logic [byte_w-1:0]       iss_be_q, iss_be_d;
  logic [addr_width_p-1:0] iss_addr_q, iss_addr_d;
  logic [data_width_p-1:0] iss_wdata_q, iss_wdata_d;

  logic                    wb_valid_q, wb_valid_d;
  logic [rd_width_p-1:0]   wb_rd_q, wb_rd_d;
  logic [data_width_p-1:0] wb_data_q, wb_data_d;

  logic exc_q, exc_d;

  logic              req_ready;
  logic              accept;
  logic              push;
  logic              mis;
  logic [off_w-1:0]  req_off;
  logic [byte_w-1:0] smask;
  trk_t              head;
  logic              pop;
  logic              sbit;
  logic [data_width_p-1:0] sh;
  logic [data_width_p-1:0] ext;

  function automatic logic [ptr_w-1:0] nxt(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(outstanding_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign req_off = bus.req_addr_i[off_w-1:0];

  // Misaligned requests are swallowed: accepted, never tracked or issued.
  always_comb begin
    mis = 1'b0;
    unique case (bus.req_size_i)
      2'b01:   mis = bus.req_addr_i[0];
      2'b10:   mis = |bus.req_addr_i[1:0];
      2'b11:   mis = (data_width_p == 32) || (|bus.req_addr_i[2:0]);
      default: mis = 1'b0;
    endcase
  end

  always_comb begin
    smask = '0;
    for (int i = 0; i < byte_w; i++) begin
      smask[i] = (i < (1 << bus.req_size_i));
    end
  end

  assign req_ready = ~exc_q
                   & (count_q < cnt_w'(outstanding_p))
                   & (~iss_valid_q | bus.mem_yumi_i);
  assign accept = bus.req_valid_i & req_ready;
  assign push   = accept & ~mis;

  assign head = fifo_q[rd_ptr_q];
  assign pop  = (count_q != '0) & bus.mem_rvalid_i
              & (head.wen | ~wb_valid_q | bus.wb_yumi_i);

  assign sh = bus.mem_rdata_i >> {head.off, 3'b000};

  always_comb begin
    sbit = 1'b0;
    unique case (head.size)
      2'b00:   sbit = sh[7];
      2'b01:   sbit = sh[15];
      2'b10:   sbit = sh[31];
      default: sbit = sh[data_width_p-1];
    endcase
  end

  always_comb begin
    ext = '0;
    for (int i = 0; i < data_width_p; i++) begin
      ext[i] = (i < (8 << head.size)) ? sh[i] : (head.sgn & sbit);
    end
  end

  always_comb begin
    iss_valid_d = iss_valid_q;
    iss_wen_d   = iss_wen_q;
    iss_be_d    = iss_be_q;
    iss_addr_d  = iss_addr_q;
    iss_wdata_d = iss_wdata_q;
    if (push) begin
      iss_valid_d = 1'b1;
      iss_wen_d   = bus.req_wen_i;
      iss_be_d    = smask << req_off;
      iss_addr_d  = {bus.req_addr_i[addr_width_p-1:off_w], {off_w{1'b0}}};
      iss_wdata_d = bus.req_wdata_i << {req_off, 3'b000};
    end else if (bus.mem_yumi_i) begin
      iss_valid_d = 1'b0;
    end
  end

  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    if (pop & ~head.wen) begin
      wb_valid_d = 1'b1;
      wb_rd_d    = head.rd;
      wb_data_d  = ext;
    end else if (bus.wb_yumi_i) begin
      wb_valid_d = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d = push ? nxt(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? nxt(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + cnt_w'(push) - cnt_w'(pop);
    exc_d    = exc_q | (accept & mis);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      iss_valid_q <= 1'b0;
      iss_wen_q   <= 1'b0;
      iss_be_q    <= '0;
      iss_addr_q  <= '0;
      iss_wdata_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      exc_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      iss_valid_q <= iss_valid_d;
      iss_wen_q   <= iss_wen_d;
      iss_be_q    <= iss_be_d;
      iss_addr_q  <= iss_addr_d;
      iss_wdata_q <= iss_wdata_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      exc_q       <= exc_d;
    end
  end

  // Entry payload needs no reset; occupancy is governed by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= '{wen:  bus.req_wen_i,
                            size: bus.req_size_i,
                            sgn:  bus.req_signed_i,
                            off:  req_off,
                            rd:   bus.req_rd_i};
    end
  end

  assign bus.req_ready_o = req_ready;
  assign bus.mem_valid_o = iss_valid_q;
  assign bus.mem_wen_o   = iss_wen_q;
  assign bus.mem_be_o    = iss_be_q;
  assign bus.mem_addr_o  = iss_addr_q;
  assign bus.mem_wdata_o = iss_wdata_q;
  assign bus.mem_ryumi_o = pop;
  assign bus.wb_valid_o  = wb_valid_q;
  assign bus.wb_rd_o     = wb_rd_q;
  assign bus.wb_data_o   = wb_data_q;
  assign bus.busy_o      = (count_q != '0) | wb_valid_q;
  assign bus.exception_o = exc_q;

`ifdef CORE_LSU_STATS_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (bus.req_valid_i & ~req_ready & ~&stall_q) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles_o = stall_q;
`endif

endmodule

// File: doc/core_lsu.md
Name: core_lsu

Overview:
Parametrised load/store unit that replaces the core's single-outstanding memory stage.
- Accepts LD/ST requests from the core pipeline and issues them to data memory using the valid/yumi handshake.
- Keeps up to outstanding_p requests in flight and returns load results in order to register-file writeback.
- Adds what the old memory stage lacked: byte/halfword/word/doubleword sizes with sign/zero extension, byte enables, and misalignment exceptions.

Parameters:
data_width_p, 32, memory data width in bits; 32 or 64 only
addr_width_p, 32, byte address width
outstanding_p, 2, max requests in flight (issued or awaiting response); 1 to 8
rd_width_p, 5, destination register tag width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid_i  in  1  core request valid
req_ready_o  out  1  LSU can accept a request this cycle
req_wen_i  in  1  1 = store, 0 = load
req_size_i  in  2  00 byte, 01 half, 10 word, 11 double
req_signed_i  in  1  sign-extend load result
req_addr_i  in  addr_width_p  byte address
req_wdata_i  in  data_width_p  store data, right-aligned
req_rd_i  in  rd_width_p  load destination tag
mem_valid_o  out  1  request to dmem valid
mem_yumi_i  in  1  dmem accepted request
mem_wen_o  out  1  store
mem_be_o  out  data_width_p/8  byte enables
mem_addr_o  out  addr_width_p  address, aligned to data_width_p/8
mem_wdata_o  out  data_width_p  lane-shifted store data
mem_rvalid_i  in  1  dmem response valid (one per request, loads and stores)
mem_rdata_i  in  data_width_p  response data
mem_ryumi_o  out  1  response consumed
wb_valid_o  out  1  load result valid
wb_rd_o  out  rd_width_p  load destination tag
wb_data_o  out  data_width_p  extended load data
wb_yumi_i  in  1  writeback consumed
busy_o  out  1  any request in flight or wb_valid_o high
exception_o  out  1  sticky misalignment exception

Behaviour:
- Reset: all outputs 0; issue register empty; tracking FIFO empty; count = 0; exception cleared. Reset mid-operation discards all in-flight state, and late dmem responses after reset are ignored while count = 0.
- Accept: req_valid_i & req_ready_o.
  - req_ready_o = ~exception_o & (count < outstanding_p) & (issue register empty | mem_yumi_i).
  - req_ready_o does not depend on req_valid_i.
- Issue register: one entry driving mem_*_o. Accepted request appears on mem_valid_o the next cycle and holds stable until mem_yumi_i. If accept and mem_yumi_i occur in the same cycle, the register reloads with no bubble.
- Tracking FIFO: depth outstanding_p. Each entry holds {wen, size, signed, byte offset, rd}.
  - Pushed on accept.
  - Popped when mem_rvalid_i & mem_ryumi_o.
  - count = FIFO occupancy. Simultaneous push and pop leaves count unchanged. Pointers wrap modulo outstanding_p.
- Alignment:
  - Misaligned: half with addr[0]≠0; word with addr[1:0]≠0; double with addr[2:0]≠0; any double when data_width_p = 32.
  - A misaligned request is accepted but not pushed or issued; exception_o rises the next cycle.
  - exception_o stays high until reset, and req_ready_o is 0 while it is high.
  - In-flight requests still drain.
- Lanes:
  - offset = addr[log2(data_width_p/8)-1:0].
  - mem_be_o = size mask << offset.
  - mem_wdata_o = req_wdata_i << (8*offset).
  - mem_addr_o has its offset bits zeroed.
- Responses are in order.
  - FIFO head is a store: mem_ryumi_o = mem_rvalid_i; data discarded.
  - FIFO head is a load: mem_ryumi_o = mem_rvalid_i & (~wb_valid_o | wb_yumi_i).
  - Load data = (mem_rdata_i >> 8*offset) truncated to size, then sign-extended if signed, otherwise zero-extended. It is registered into wb_*: latency is one cycle from response consumption to wb_valid_o.
  - wb_valid_o holds until wb_yumi_i. Back-to-back loads produce one result per cycle.
- mem_rvalid_i with count = 0 is a protocol violation: ignored, with mem_ryumi_o = 0.

Optional Feature:
CORE_LSU_STATS_EN
- Defined: adds output stall_cycles_o[31:0], a saturating counter of cycles with req_valid_i & ~req_ready_o. Cleared on reset; holds at 0xFFFFFFFF on saturation.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Word store at 0x0000_0104, wdata 0xDEADBEEF, immediate yumi → mem_valid_o one cycle after accept, mem_be_o = 4'b1111, mem_addr_o = 0x104; store response consumed with no wb_valid_o.
- Byte load at 0x103, signed, mem_rdata_i 0x80FF_0000 → wb_data_o = 0xFFFFFF80, wb_rd_o = req tag; same load unsigned → 0x00000080.
- outstanding_p = 2: three back-to-back loads, dmem holds responses → req_ready_o = 0 on the third until the first response is consumed; results return in order, one per cycle.
- Half load at 0x101 → exception_o = 1 the next cycle; mem_valid_o is never raised for it; req_ready_o = 0 until reset; a prior in-flight load still writes back.
- wb_yumi_i held 0 with two load responses pending → mem_ryumi_o = 0 for the second; nothing is lost after wb_yumi_i.
- reset asserted with two loads in flight → next cycle count = 0, wb_valid_o = 0, mem_valid_o = 0, busy_o = 0; with CORE_LSU_STATS_EN, stall_cycles_o = 0.
